// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared constants, state encoding and tx byte selection for the PSX pad responder
package psx_pkg;

    localparam logic [7:0] CMD_START     = 8'h01;
    localparam logic [7:0] CMD_POLL      = 8'h42;
    localparam logic [7:0] STATUS_BYTE   = 8'h5A;
    localparam logic [7:0] IDLE_BYTE     = 8'hFF;
    localparam logic [2:0] LAST_BYTE_IDX = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_ACK_WAIT  = 3'd2,
        ST_ACK_PULSE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ABORT     = 3'd5
    } state_t;

    function automatic logic [7:0] tx_byte_for(
        input logic [2:0]  idx,
        input logic [7:0]  pad_id,
        input logic [15:0] snap
    );
        case (idx)
            3'd1:    tx_byte_for = pad_id;
            3'd2:    tx_byte_for = STATUS_BYTE;
            3'd3:    tx_byte_for = snap[7:0];
            3'd4:    tx_byte_for = snap[15:8];
            default: tx_byte_for = IDLE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// rtl/psx_sync_edge.sv - 2-flop synchronizer (resets high) with rise/fall pulses on the synced value
module psx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_q    = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/psx_pad_responder.sv
// rtl/psx_pad_responder.sv - digital pad responder: answers the console poll with ID, status and buttons
module psx_pad_responder
    import psx_pkg::*;
#(
    parameter int          ACK_DELAY = 2,
    parameter int          ACK_WIDTH = 2,
    parameter logic [7:0]  PAD_ID    = 8'h41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic        poll_done,
    output logic        abort
);

    logic w_clk_q, w_clk_rise, w_clk_fall;
    logic w_cmd_q, w_cmd_rise, w_cmd_fall;
    logic w_att_q, w_att_rise, w_att_fall;
    logic w_unused;

    psx_sync_edge u_sync_clk (
        .clk(clk), .rst_n(rst_n), .i_d(psx_clk),
        .o_q(w_clk_q), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );
    psx_sync_edge u_sync_cmd (
        .clk(clk), .rst_n(rst_n), .i_d(cmd),
        .o_q(w_cmd_q), .o_rise(w_cmd_rise), .o_fall(w_cmd_fall)
    );
    psx_sync_edge u_sync_att (
        .clk(clk), .rst_n(rst_n), .i_d(att),
        .o_q(w_att_q), .o_rise(w_att_rise), .o_fall(w_att_fall)
    );

    assign w_unused = ^{w_clk_q, w_cmd_rise, w_cmd_fall, w_att_q};

    state_t      r_state;
    logic [2:0]  r_byte_idx;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [15:0] r_btn_snap;
    logic [7:0]  r_ack_cnt;
    logic        r_data;
    logic        r_ack;
    logic        r_poll_done;
    logic        r_abort;

    logic [7:0]  w_rx_full;
    logic        w_mismatch;

    // The 8th bit is still in flight when the byte completes, so check it directly.
    assign w_rx_full  = {w_cmd_q, r_rx[6:0]};
    assign w_mismatch = ((r_byte_idx == 3'd0) && (w_rx_full != CMD_START)) ||
                        ((r_byte_idx == 3'd1) && (w_rx_full != CMD_POLL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_byte_idx  <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_tx        <= IDLE_BYTE;
            r_rx        <= 8'h00;
            r_btn_snap  <= 16'hFFFF;
            r_ack_cnt   <= 8'd0;
            r_data      <= 1'b1;
            r_ack       <= 1'b1;
            r_poll_done <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_poll_done <= 1'b0;
            r_abort     <= 1'b0;
            if (w_att_rise) begin
                r_state   <= ST_IDLE;
                r_data    <= 1'b1;
                r_ack     <= 1'b1;
                r_ack_cnt <= 8'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_data <= 1'b1;
                        r_ack  <= 1'b1;
                        if (w_att_fall) begin
                            r_btn_snap <= buttons;
                            r_tx       <= IDLE_BYTE;
                            r_rx       <= 8'h00;
                            r_bit_cnt  <= 3'd0;
                            r_byte_idx <= 3'd0;
                            r_state    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT, ST_ACK_WAIT, ST_ACK_PULSE: begin
                        if (r_state == ST_ACK_WAIT) begin
                            if (r_ack_cnt == 8'(ACK_DELAY - 1)) begin
                                r_state   <= ST_ACK_PULSE;
                                r_ack     <= 1'b0;
                                r_ack_cnt <= 8'd0;
                            end else begin
                                r_ack_cnt <= r_ack_cnt + 8'd1;
                            end
                        end else if (r_state == ST_ACK_PULSE) begin
                            if (r_ack_cnt == 8'(ACK_WIDTH - 1)) begin
                                r_state    <= ST_SHIFT;
                                r_ack      <= 1'b1;
                                r_ack_cnt  <= 8'd0;
                                r_byte_idx <= (r_byte_idx == LAST_BYTE_IDX) ? LAST_BYTE_IDX
                                                                            : r_byte_idx + 3'd1;
                            end else begin
                                r_ack_cnt <= r_ack_cnt + 8'd1;
                            end
                        end

                        if (w_clk_fall) begin
                            r_data <= r_tx[r_bit_cnt];
                        end
                        if (w_clk_rise) begin
                            r_rx[r_bit_cnt] <= w_cmd_q;
                            r_bit_cnt       <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_mismatch) begin
                                    r_state <= ST_ABORT;
                                    r_abort <= 1'b1;
                                    r_data  <= 1'b1;
                                end else if (r_byte_idx == LAST_BYTE_IDX) begin
                                    r_state     <= ST_DONE;
                                    r_poll_done <= 1'b1;
                                    r_data      <= 1'b1;
                                end else begin
                                    r_state   <= ST_ACK_WAIT;
                                    r_ack_cnt <= 8'd0;
                                    r_tx      <= tx_byte_for(r_byte_idx + 3'd1, PAD_ID, r_btn_snap);
                                end
                            end
                        end
                    end
                    ST_DONE, ST_ABORT: begin
                        r_data <= 1'b1;
                        r_ack  <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_data  <= 1'b1;
                        r_ack   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign data      = r_data;
    assign ack       = r_ack;
    assign poll_done = r_poll_done;
    assign abort     = r_abort;

endmodule

// File: tb/tb_psx_pad_responder.sv
// tb/tb_psx_pad_responder.sv - console-model bench with byte and event scoreboards for psx_pad_responder
module tb_psx_pad_responder;

    localparam int H      = 5;
    localparam int GAP    = 12;
    localparam int EV_ACK   = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ABORT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psx_clk = 1'b1;
    logic        cmd = 1'b1;
    logic        att = 1'b1;
    logic [15:0] buttons = 16'hFFFF;
    logic        data;
    logic        ack;
    logic        poll_done;
    logic        abort;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_bytes[$];
    int         exp_ev[$];

    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         ack_run = 0;

    always #5 clk = ~clk;

    psx_pad_responder dut (
        .clk(clk), .rst_n(rst_n), .psx_clk(psx_clk), .cmd(cmd), .att(att),
        .buttons(buttons), .data(data), .ack(ack), .poll_done(poll_done), .abort(abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pop_event(input int code);
        if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d required=none", code);
        end else begin
            check("event", 32'(code), 32'(exp_ev.pop_front()));
        end
    endtask

    // Console side: samples data on each psx_clk rise, discards partial bytes when att rises.
    initial begin
        forever begin
            @(posedge psx_clk or posedge att);
            if (att) begin
                rx_cnt = 0;
            end else begin
                rx_sh = {data, rx_sh[7:1]};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte actual=%0h required=none", rx_sh);
                    end else begin
                        check("rx_byte", 32'(rx_sh), 32'(exp_bytes.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_run = 0;
            end else begin
                if (ack === 1'b0) begin
                    ack_run++;
                end else if (ack_run > 0) begin
                    check("ack_width", 32'(ack_run), 32'd2);
                    pop_event(EV_ACK);
                    ack_run = 0;
                end
                if (poll_done === 1'b1) pop_event(EV_DONE);
                if (abort === 1'b1) pop_event(EV_ABORT);
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            psx_clk = 1'b0;
            cmd     = b[i];
            clk_n(H);
            psx_clk = 1'b1;
            clk_n(H - 1);
        end
        cmd = 1'b1;
        clk_n(gap);
    endtask

    task automatic att_low();
        @(negedge clk);
        att = 1'b0;
        clk_n(6);
    endtask

    task automatic att_high();
        @(negedge clk);
        att = 1'b1;
        clk_n(8);
    endtask

    task automatic expect_byte(input logic [7:0] b, input int ev);
        exp_bytes.push_back(b);
        if (ev != 0) exp_ev.push_back(ev);
    endtask

    task automatic drain_check(input string name);
        clk_n(4);
        check({name, "_bytes_pending"}, 32'(exp_bytes.size()), 32'd0);
        check({name, "_events_pending"}, 32'(exp_ev.size()), 32'd0);
    endtask

    task automatic full_poll(input string name, input logic [15:0] btn,
                             input logic [7:0] exp3, input logic [7:0] exp4);
        buttons = btn;
        att_low();
        expect_byte(8'hFF, EV_ACK);  send_byte(8'h01, 8, GAP);
        expect_byte(8'h41, EV_ACK);  send_byte(8'h42, 8, GAP);
        expect_byte(8'h5A, EV_ACK);  send_byte(8'h00, 8, GAP);
        expect_byte(exp3,  EV_ACK);  send_byte(8'h00, 8, GAP);
        expect_byte(exp4,  EV_DONE); send_byte(8'h00, 8, GAP);
        att_high();
        drain_check(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        clk_n(3);
        check("reset_data", 32'(data), 32'd1);
        check("reset_ack", 32'(ack), 32'd1);
        check("reset_poll_done", 32'(poll_done), 32'd0);
        check("reset_abort", 32'(abort), 32'd0);
        rst_n = 1'b1;
        clk_n(4);

        full_poll("normal", 16'hFFEF, 8'hEF, 8'hFF);

        att_low();
        expect_byte(8'hFF, EV_ABORT); send_byte(8'h81, 8, GAP);
        expect_byte(8'hFF, 0);        send_byte(8'h00, 8, GAP);
        check("abort_data_high", 32'(data), 32'd1);
        att_high();
        drain_check("bad_start");
        full_poll("after_abort", 16'h7E81, 8'h81, 8'h7E);

        att_low();
        expect_byte(8'hFF, EV_ACK);   send_byte(8'h01, 8, GAP);
        expect_byte(8'h41, EV_ABORT); send_byte(8'h43, 8, GAP);
        expect_byte(8'hFF, 0);        send_byte(8'h00, 8, GAP);
        att_high();
        drain_check("bad_cmd");

        att_low();
        expect_byte(8'hFF, EV_ACK); send_byte(8'h01, 8, GAP);
        expect_byte(8'h41, EV_ACK); send_byte(8'h42, 8, GAP);
        send_byte(8'h00, 3, 0);
        check("cancel_data_before", 32'(data), 32'd0);
        @(negedge clk);
        att = 1'b1;
        clk_n(3);
        check("cancel_data", 32'(data), 32'd1);
        check("cancel_ack", 32'(ack), 32'd1);
        clk_n(8);
        drain_check("cancel");
        full_poll("after_cancel", 16'h1234, 8'h34, 8'h12);

        buttons = 16'hFFFF;
        att_low();
        expect_byte(8'hFF, EV_ACK); send_byte(8'h01, 8, GAP);
        expect_byte(8'h41, EV_ACK); send_byte(8'h42, 8, GAP);
        expect_byte(8'h5A, EV_ACK); send_byte(8'h00, 4, 0);
        buttons = 16'h0000;
        send_byte(8'h00, 4, GAP);
        expect_byte(8'hFF, EV_ACK);  send_byte(8'h00, 8, GAP);
        expect_byte(8'hFF, EV_DONE); send_byte(8'h00, 8, GAP);
        att_high();
        drain_check("btn_change");

        att_low();
        expect_byte(8'hFF, EV_ACK); send_byte(8'h01, 8, GAP);
        expect_byte(8'h41, 0);      send_byte(8'h42, 8, 0);
        k = 0;
        while (ack !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ack_low_before_reset", 32'(ack), 32'd0);
        check("data_before_reset", 32'(data), 32'd0);
        #2;
        rst_n = 1'b0;
        att   = 1'b1;
        #1;
        check("async_reset_ack", 32'(ack), 32'd1);
        check("async_reset_data", 32'(data), 32'd1);
        clk_n(3);
        rst_n = 1'b1;
        clk_n(5);
        check("post_reset_data", 32'(data), 32'd1);
        check("post_reset_ack", 32'(ack), 32'd1);
        check("post_reset_poll_done", 32'(poll_done), 32'd0);
        drain_check("reset");
        full_poll("after_reset", 16'hA55A, 8'h5A, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
